// File: rtl/hsid_x_obi_mem.sv
// -----------------------------------------------------------------------------
// hsid_x_obi_mem
//
// OBI responder memory. It backs the OBI master port of the HSID-X
// accelerator top level in block- and system-level benches, and holds pixel
// and library data.
//
// Word-wide reads and writes go into an internal word array. Every accepted
// request gets exactly one response, RSP_LATENCY cycles later, in acceptance
// order.
//
// Package hsid_x_obi_inf_pkg (defined first in this file) gives the request
// and response structs.
//
// Parameters
//   WORD_WIDTH   data word width, must be 32 (OBI rdata/wdata width)
//   MEM_WORDS    number of words in the array, power of two
//   RSP_LATENCY  cycles from acceptance to rvalid, 1..8
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   obi_req_i    request: req, addr (byte address), we, be, wdata
//   obi_rsp_o    response: gnt, rvalid, rdata
//   gnt_stall_i  forces gnt low, used to inject grant back-pressure
// -----------------------------------------------------------------------------

package hsid_x_obi_inf_pkg;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

module hsid_x_obi_mem #(
   parameter int WORD_WIDTH  = 32,
   parameter int MEM_WORDS   = 4096,
   parameter int RSP_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  hsid_x_obi_inf_pkg::obi_req_t  obi_req_i,
   output hsid_x_obi_inf_pkg::obi_resp_t obi_rsp_o,
   input  logic                         gnt_stall_i
);

   localparam int MEM_ADDR  = $clog2(MEM_WORDS);
   localparam int NUM_BYTES = WORD_WIDTH / 8;

   // ------------------------------------------------------------------
   // Grant and acceptance
   // ------------------------------------------------------------------

   // rst_n_q_reg is low for the whole reset and for the first cycle after
   // release. This keeps gnt low until the responder is settled.
   logic rst_n_q_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst_n_q_reg <= 1'b0;
      end else begin
         rst_n_q_reg <= 1'b1;
      end
   end

   logic gnt;
   logic accept;

   assign gnt = rst_n_q_reg & ~gnt_stall_i;

   // rst_n is also qualified in here. An edge that applies reset must not
   // write the array, even if gnt was still high in that first reset cycle.
   assign accept = obi_req_i.req & gnt & rst_n;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [MEM_ADDR-1:0] word_idx;
   logic                in_range;
   logic [1:0]          unused_byte_offset;

   assign word_idx           = obi_req_i.addr[MEM_ADDR+1:2];
   assign in_range           = (obi_req_i.addr[31:MEM_ADDR+2] == '0);
   assign unused_byte_offset = obi_req_i.addr[1:0];

   // ------------------------------------------------------------------
   // Word array with byte-lane writes and a registered read
   // ------------------------------------------------------------------
   logic [WORD_WIDTH-1:0] mem_reg [MEM_WORDS];
   logic [NUM_BYTES-1:0]  byte_we;

   // A lane is written only when the write is accepted, falls inside the
   // array and has its byte enable set. Out-of-range writes are dropped.
   generate
      for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_we
         assign byte_we[gi] = accept & obi_req_i.we & in_range & obi_req_i.be[gi];
      end
   endgenerate

   // ram_q_reg is response stage 0. It captures the word as it was before
   // the accepting edge.
   // Write responses and out-of-range reads load zero, so rdata carries no
   // array data for them.
   // The array has no reset, because its contents must survive a reset.
   logic [WORD_WIDTH-1:0] ram_q_reg;

   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
         if (byte_we[b]) begin
            mem_reg[word_idx][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
         end
      end
      if (accept) begin
         if (obi_req_i.we || !in_range) begin
            ram_q_reg <= '0;
         end else begin
            ram_q_reg <= mem_reg[word_idx];
         end
      end
   end

   // ------------------------------------------------------------------
   // Response pipeline: RSP_LATENCY stages of {valid, data}
   // ------------------------------------------------------------------
   // Only the valid bits are reset. Data in a stage whose valid bit is
   // clear is never driven onto the bus, so it does not matter.
   logic [RSP_LATENCY-1:0] vld_reg;
   logic [RSP_LATENCY-1:0] vld_next;
   logic [WORD_WIDTH-1:0]  last_data;

   generate
      for (genvar gi = 0; gi < RSP_LATENCY; gi++) begin : g_vld_next
         if (gi == 0) begin : g_head
            assign vld_next[gi] = accept;
         end else begin : g_shift
            assign vld_next[gi] = vld_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_reg <= '0;
      end else begin
         vld_reg <= vld_next;
      end
   end

   // Data stages after stage 0. With a latency of one, the RAM output
   // register drives the bus directly.
   generate
      if (RSP_LATENCY == 1) begin : g_no_tail
         assign last_data = ram_q_reg;
      end else begin : g_tail
         logic [RSP_LATENCY-2:0][WORD_WIDTH-1:0] tail_reg;

         always_ff @(posedge clk) begin
            tail_reg[0] <= ram_q_reg;
            for (int i = 1; i < RSP_LATENCY - 1; i++) begin
               tail_reg[i] <= tail_reg[i-1];
            end
         end

         assign last_data = tail_reg[RSP_LATENCY-2];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Response outputs
   // ------------------------------------------------------------------
   // rdata is forced to zero whenever rvalid is low, so stale data never
   // appears on the bus.
   always_comb begin
      obi_rsp_o        = '0;
      obi_rsp_o.gnt    = gnt;
      obi_rsp_o.rvalid = vld_reg[RSP_LATENCY-1];
      obi_rsp_o.rdata  = vld_reg[RSP_LATENCY-1] ? last_data : '0;
   end

endmodule
